// File: rtl/ccd_dmem_writer.sv
// CCD capture packer: gathers 16-bit pixels into 256-bit rows through a ping-pong
// line buffer and writes them to consecutive DMEM port-B rows, yielding to accelerator reads.
module ccd_dmem_writer #(
  parameter logic [6:0] BASE_ADDR = 7'h00,
  parameter int         NUM_ROWS  = 49
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ccd_en,
  input  logic         pix_valid,
  input  logic [15:0]  pix_data,
  input  logic         acc_rd_busy,
  output logic         ccd_dmem_wren,
  output logic [6:0]   ccd_dmem_addr,
  output logic [255:0] ccd_dmem_data,
  output logic         ccd_done,
  output logic         ccd_overflow
);

  typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN, DONE} state_t;

  localparam logic [7:0] ROWS = 8'(NUM_ROWS);

  state_t       state, state_nxt;
  logic [255:0] line_buf [2];
  logic [1:0]   full;
  logic         fill_sel, rd_sel;
  logic [3:0]   pix_idx;
  logic [7:0]   fill_cnt, wr_cnt;
  logic [6:0]   wr_ptr;
  logic         ovf_flag;

  logic running, rows_open, accept, drop, wren, last_write, start, abort;

  always_comb begin
    running    = (state == CAPTURE) || (state == DRAIN);
    start      = (state == IDLE) && ccd_en;
    abort      = running && !ccd_en;
    rows_open  = (state == CAPTURE) && ccd_en && (fill_cnt < ROWS);
    // Full flags are registered: a buffer freed this cycle only takes pixels next cycle.
    accept     = rows_open && pix_valid && !full[fill_sel];
    drop       = rows_open && pix_valid && full[fill_sel];
    wren       = running && ccd_en && full[rd_sel] && !acc_rd_busy;
    last_write = wren && (wr_cnt == ROWS - 8'd1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (ccd_en) state_nxt = CAPTURE;
      CAPTURE: begin
        if (!ccd_en)              state_nxt = IDLE;
        else if (last_write)      state_nxt = DONE;
        else if (fill_cnt == ROWS) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (!ccd_en)         state_nxt = IDLE;
        else if (last_write) state_nxt = DONE;
      end
      DONE:    if (!ccd_en) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ccd_dmem_wren = wren;
    ccd_dmem_addr = wr_ptr;
    ccd_dmem_data = full[rd_sel] ? line_buf[rd_sel] : '0;
    ccd_done      = (state == DONE);
    ccd_overflow  = ovf_flag;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || start) begin
      full     <= 2'b00;
      fill_sel <= 1'b0;
      rd_sel   <= 1'b0;
      pix_idx  <= 4'd0;
      fill_cnt <= 8'd0;
      wr_cnt   <= 8'd0;
      wr_ptr   <= BASE_ADDR;
      ovf_flag <= 1'b0;
    end else if (abort) begin
      full <= 2'b00;
    end else begin
      // Write and fill never target the same buffer: one must be full, the other empty.
      if (wren) begin
        full[rd_sel] <= 1'b0;
        rd_sel       <= ~rd_sel;
        wr_ptr       <= wr_ptr + 7'd1;
        wr_cnt       <= wr_cnt + 8'd1;
      end
      if (accept) begin
        pix_idx <= pix_idx + 4'd1;
        if (pix_idx == 4'd15) begin
          full[fill_sel] <= 1'b1;
          fill_sel       <= ~fill_sel;
          fill_cnt       <= fill_cnt + 8'd1;
        end
      end
      if (drop) ovf_flag <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) line_buf[fill_sel][{pix_idx, 4'h0} +: 16] <= pix_data;
  end

endmodule
